// File: rtl/sensor_conditioner.sv
// sensor_conditioner
//   Input conditioning stage ahead of the sensor error decoder. Each raw,
//   asynchronous sensor line is brought into the clk domain through a 2-flop
//   synchronizer and then debounced by its own stability counter. A new level
//   is accepted only after it has differed from the stable value for
//   DEBOUNCE_CYCLES consecutive enabled cycles.
//
// Ports
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   en             debounce enable; counters and clean outputs freeze when low
//   sensors_raw    raw asynchronous sensor lines
//   sensors_clean  debounced stable sensor vector (to the error decoder)
//   changed        one-cycle pulse in the cycle a new sensors_clean is visible
//   busy           high while any per-bit counter is nonzero
module sensor_conditioner #(
    parameter int NUM_SENSORS     = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   en,
    input  logic [NUM_SENSORS-1:0] sensors_raw,
    output logic [NUM_SENSORS-1:0] sensors_clean,
    output logic                   changed,
    output logic                   busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SENSORS-1:0]                s1_q, s1_d;
    logic [NUM_SENSORS-1:0]                s2_q, s2_d;
    logic [NUM_SENSORS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_SENSORS-1:0]                clean_q, clean_d;
    logic                                  changed_q, changed_d;
    logic                                  busy_q, busy_d;

    always_comb begin
        // Synchronizer keeps sampling even while debouncing is disabled.
        s1_d      = sensors_raw;
        s2_d      = s1_q;
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        changed_d = 1'b0;
        busy_d    = 1'b0;

        if (en) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (s2_q[i] == clean_q[i]) begin
                    // Any return to the stable level restarts the count.
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    // Counter clears on acceptance, so it never wraps.
                    clean_d[i] = s2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
            // Simultaneous bit updates collapse into a single pulse.
            changed_d = |(clean_d ^ clean_q);
        end

        for (int i = 0; i < NUM_SENSORS; i++) begin
            busy_d = busy_d | (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cnt_q     <= '0;
            clean_q   <= '0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    assign sensors_clean = clean_q;
    assign changed       = changed_q;
    assign busy          = busy_q;

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Input conditioning stage that sits directly upstream of the sensor error decoder.
- Takes raw asynchronous sensor lines and brings each one into the clock domain through a 2-flop synchronizer.
- Debounces each line independently with a per-bit stability counter.
- Presents a clean, stable sensor vector to the decoder, plus a one-cycle change strobe and a busy status.

Parameters:
- NUM_SENSORS, 4: number of independent sensor lines.
- DEBOUNCE_CYCLES, 8: consecutive enabled cycles a synchronized value must differ from the stable value before it is accepted. Legal range is at least 1.
- CNT_WIDTH, 4: width of each per-bit counter. It must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- en  input  1  debounce enable. When low, counters and stable outputs hold while the synchronizers keep running.
- sensors_raw  input  NUM_SENSORS  raw asynchronous sensor lines.
- sensors_clean  output  NUM_SENSORS  debounced stable sensor vector; this feeds the error decoder's sensors input.
- changed  output  1  one-cycle pulse when any bit of sensors_clean updates.
- busy  output  1  high while any per-bit counter is nonzero.

Behaviour:
- Reset (n_rst low, asynchronous): all synchronizer flops, counters, sensors_clean, changed and busy are forced to 0. Everything is held at 0 while n_rst stays low. Normal operation resumes on the first rising edge after deassertion.
- Synchronizer, per bit: s1 <= sensors_raw[i]; s2 <= s1. The synchronizer runs regardless of en.
- Debounce, per bit i, on each rising edge with en=1:
  - If s2[i] == sensors_clean[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: sensors_clean[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- en=0: cnt and sensors_clean hold, and changed is 0.
- changed is registered. It is 1 in exactly the cycle in which the updated sensors_clean is first visible, and 0 otherwise. If several bits update on the same edge, changed produces a single pulse.
- busy is a registered OR of the next-state counters: busy=1 exactly when any cnt[i] is nonzero after the edge.
- Latency: a raw step held stable, with en=1 throughout, appears on sensors_clean after the (DEBOUNCE_CYCLES+2)th rising edge following the step. That is 10 edges at the default; 3 edges when DEBOUNCE_CYCLES=1.
- Glitch rejection: a synchronized deviation lasting fewer than DEBOUNCE_CYCLES consecutive enabled cycles never reaches sensors_clean. Any return to the stable value clears that bit's counter, so bounce restarts the count.
- Independence: each bit has its own counter. Different bits may update on different edges, and each such edge produces its own changed pulse.
- Counter never wraps: the maximum count reached is DEBOUNCE_CYCLES-1, because the counter clears on acceptance.
- Reset mid-count: a pending transition is discarded. sensors_clean returns to 0 immediately and asynchronously, without waiting for a clock edge.
- en toggling mid-count: the count is frozen, not cleared. It resumes when en returns high, provided s2 still differs from the stable value.

Test Plan:
1. Reset release with sensors_raw=4'b0000 held: sensors_clean=0, changed=0 and busy=0 for all cycles.
2. en=1, sensors_raw steps 0000->0001 and holds. Required:
   - sensors_clean=0001 after edge 10.
   - changed=1 only during the cycle following edge 10.
   - busy=1 from edge 3 to edge 9, then 0 after edge 10.
3. Bounce: sensors_raw[1] toggles 1 for 5 cycles, 0 for 1 cycle, then 1 held. Required:
   - No update from the first burst.
   - sensors_clean[1]=1 after the 10th edge after the final rise.
   - Exactly one changed pulse.
4. Simultaneous update: bits 3 and 1 rise in the same cycle and hold. Required: sensors_clean goes 0000->1010 on a single edge, with one changed pulse. The downstream decoder would then see an error condition.
5. en gating: raise bit 2, then drop en for 4 cycles after 3 counts have accumulated. Required: the update occurs 4 edges later than in scenario 2's timing, and changed never pulses while en=0.
6. Reset mid-operation:
   - Stage 1: with sensors_clean=0101, change raw to 1010, then assert n_rst for 2 cycles at count 5. Required: sensors_clean=0000 immediately, busy=0.
   - Stage 2: deassert n_rst with 1010 held. Required: sensors_clean=1010 after 10 edges.
